// File: rtl/axi_stream_pkt_arbiter_if.sv
// Bundle of the arbiter's stream signals: NUM_SRC upstream lanes on the input side and one
// merged lane plus the owning source index on the output side.
interface axi_stream_pkt_arbiter_if #(
    parameter int NUM_SRC      = 4,
    parameter int SRC_WD       = 2,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
);
    logic [NUM_SRC-1:0]              valid_in;
    logic [NUM_SRC*DATA_WD-1:0]      data_in;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] keep_in;
    logic [NUM_SRC-1:0]              last_in;
    logic [NUM_SRC-1:0]              ready_in;
    logic                            valid_out;
    logic [DATA_WD-1:0]              data_out;
    logic [DATA_BYTE_WD-1:0]         keep_out;
    logic                            last_out;
    logic [SRC_WD-1:0]               src_out;
    logic                            ready_out;
    logic                            busy;

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, keep_out, last_out, src_out, busy
    );

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
        output ready_in, valid_out, data_out, keep_out, last_out, src_out, busy
    );
endinterface

// File: rtl/axi_stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream sources onto one path.
// An output register plus a one-entry skid buffer give full throughput; src index rides with each beat.
module axi_stream_pkt_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int SRC_WD       = 2,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_stream_pkt_arbiter_if.slave  bus_io
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [SRC_WD-1:0]       grant_q, grant_d;
    logic [SRC_WD-1:0]       ptr_q, ptr_d;
    logic [NUM_SRC-1:0]      ready_in_q, ready_in_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WD-1:0]      out_data_q, out_data_d;
    logic [DATA_BYTE_WD-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic [SRC_WD-1:0]       out_src_q, out_src_d;

    logic                    skid_valid_q, skid_valid_d;
    logic [DATA_WD-1:0]      skid_data_q, skid_data_d;
    logic [DATA_BYTE_WD-1:0] skid_keep_q, skid_keep_d;
    logic                    skid_last_q, skid_last_d;
    logic [SRC_WD-1:0]       skid_src_q, skid_src_d;

    logic [DATA_WD-1:0]      sel_data_s;
    logic [DATA_BYTE_WD-1:0] sel_keep_s;
    logic                    sel_last_s;
    logic                    accept_s;
    logic                    consume_s;

    // Lowest-distance requester after ptr wins; iterating far-to-near lets the nearest overwrite.
    function automatic logic [SRC_WD-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                  input logic [SRC_WD-1:0]  ptr);
        logic [SRC_WD-1:0] win;
        logic [SRC_WD-1:0] idx;
        win = {SRC_WD{1'b0}};
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = SRC_WD'((int'(ptr) + k) % NUM_SRC);
            win = req[idx] ? idx : win;
        end
        return win;
    endfunction

    assign sel_data_s = bus_io.data_in[int'(grant_q) * DATA_WD +: DATA_WD];
    assign sel_keep_s = bus_io.keep_in[int'(grant_q) * DATA_BYTE_WD +: DATA_BYTE_WD];
    assign sel_last_s = bus_io.last_in[grant_q];
    // ready_in_q is only ever high on the granted lane, so this is the granted handshake.
    assign accept_s   = |(bus_io.valid_in & ready_in_q);
    assign consume_s  = out_valid_q & bus_io.ready_out;

    // Next-state for the output/skid pipeline, the grant FSM and the registered ready_in.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_src_d    = out_src_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_last_d  = skid_last_q;
        skid_src_d   = skid_src_q;
        ready_in_d   = {NUM_SRC{1'b0}};

        if (!out_valid_q || consume_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_last_d   = skid_last_q;
                out_src_d    = skid_src_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data_s;
                out_keep_d  = sel_keep_s;
                out_last_d  = sel_last_s;
                out_src_d   = grant_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_data_s;
                skid_keep_d  = sel_keep_s;
                skid_last_d  = sel_last_s;
                skid_src_d   = grant_q;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|bus_io.valid_in) begin
                    grant_d = rr_pick(bus_io.valid_in, ptr_q);
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (accept_s && sel_last_s) begin
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_BUSY) && !skid_valid_d) begin
            ready_in_d[grant_d] = 1'b1;
        end else begin
            ready_in_d = {NUM_SRC{1'b0}};
        end
    end

    // State, pointer and datapath registers; reset discards any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= {SRC_WD{1'b0}};
            ptr_q        <= SRC_WD'(NUM_SRC - 1);
            ready_in_q   <= {NUM_SRC{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_WD{1'b0}};
            out_keep_q   <= {DATA_BYTE_WD{1'b0}};
            out_last_q   <= 1'b0;
            out_src_q    <= {SRC_WD{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_WD{1'b0}};
            skid_keep_q  <= {DATA_BYTE_WD{1'b0}};
            skid_last_q  <= 1'b0;
            skid_src_q   <= {SRC_WD{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            ready_in_q   <= ready_in_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_src_q    <= out_src_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_last_q  <= skid_last_d;
            skid_src_q   <= skid_src_d;
        end
    end

    assign bus_io.ready_in  = ready_in_q;
    assign bus_io.valid_out = out_valid_q;
    assign bus_io.data_out  = out_data_q;
    assign bus_io.keep_out  = out_keep_q;
    assign bus_io.last_out  = out_last_q;
    assign bus_io.src_out   = out_src_q;
    assign bus_io.busy      = (state_q == ST_BUSY);

endmodule
